// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encoding, FSM states, slice control decode.
// Latency: n/a (package).  Backpressure: n/a.
// Contents: ALU_WIDTH_DEFAULT, op_e, state_e, slice_ctrl_t, slice_ctrl(), is_arith().
package alu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_NOR = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic       ainvert;
    logic       binvert;
    logic [1:0] sel;
  } slice_ctrl_t;

  // Reserved codes select mux leg 11, which the slice ties to 0, so they
  // run the full sequence and produce an all-zero result.
  function automatic slice_ctrl_t slice_ctrl(input logic [2:0] op);
    slice_ctrl_t c;
    c = '{ainvert: 1'b0, binvert: 1'b0, sel: 2'b11};
    case (op)
      OP_AND: c = '{ainvert: 1'b0, binvert: 1'b0, sel: 2'b00};
      OP_OR:  c = '{ainvert: 1'b0, binvert: 1'b0, sel: 2'b01};
      OP_ADD: c = '{ainvert: 1'b0, binvert: 1'b0, sel: 2'b10};
      OP_SUB: c = '{ainvert: 1'b0, binvert: 1'b1, sel: 2'b10};
      OP_NOR: c = '{ainvert: 1'b1, binvert: 1'b1, sel: 2'b00};
      default: c = '{ainvert: 1'b0, binvert: 1'b0, sel: 2'b11};
    endcase
    return c;
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu1b.sv
// 1-bit ALU slice: optional operand inversion, AND/OR/SUM select, ripple carry out.
// Latency: combinational.  Backpressure: none.
// Ports: a, b, ainvert, binvert, cin, s1, s0 -> x (selected result), cout (full-adder carry).
module alu1b (
  input  logic a,
  input  logic b,
  input  logic ainvert,
  input  logic binvert,
  input  logic cin,
  input  logic s1,
  input  logic s0,
  output logic x,
  output logic cout
);

  logic aa;
  logic bb;

  assign aa   = a ^ ainvert;
  assign bb   = b ^ binvert;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);

  always_comb begin
    x = 1'b0;
    case ({s1, s0})
      2'b00:   x = aa & bb;
      2'b01:   x = aa | bb;
      2'b10:   x = aa ^ bb ^ cin;
      default: x = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: one alu1b slice reused LSB-first over WIDTH cycles.
// Latency: done pulses WIDTH+1 edges after the start-accept edge; back-to-back period WIDTH+2.
// Backpressure: start is only accepted in IDLE; start while busy is ignored.
// Ports: clk, rst (sync, active-high), start, op[2:0], a, b -> busy, done, result, cout, zero, overflow.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cin_msb;

  slice_ctrl_t      ctrl;
  logic             slice_x;
  logic             slice_cout;

  assign ctrl = slice_ctrl(op_q);

  alu1b u_slice (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .ainvert (ctrl.ainvert),
    .binvert (ctrl.binvert),
    .cin     (carry),
    .s1      (ctrl.sel[1]),
    .s0      (ctrl.sel[0]),
    .x       (slice_x),
    .cout    (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      op_q     <= 3'b000;
      cnt      <= '0;
      carry    <= 1'b0;
      cin_msb  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            op_q   <= op;
            cnt    <= '0;
            // SUB is a + ~b + 1: the +1 enters as the initial carry.
            carry  <= (op == OP_SUB);
            result <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
          result <= {slice_x, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (is_arith(op_q)) begin
            carry <= slice_cout;
          end
          if (cnt == LAST_BIT) begin
            // The carry register currently holds the carry into the MSB.
            cin_msb <= carry;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cout     <= is_arith(op_q) & carry;
          overflow <= is_arith(op_q) & (cin_msb ^ carry);
          zero     <= (result == '0);
          state    <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 start  in  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  in  3  operation: 000 AND, 001 OR, 010 ADD, 011 SUB (a-b), 100 NOR, 101-111 reserved.
REQ-006 a  in  WIDTH  operand A, captured with start.
REQ-007 b  in  WIDTH  operand B, captured with start.
REQ-008 busy  out  1  high while in RUN or DONE.
REQ-009 done  out  1  one-cycle pulse, result and flags valid.
REQ-010 result  out  WIDTH  operation result, held until next accepted start.
REQ-011 cout  out  1  final carry for ADD/SUB, 0 for logic ops.
REQ-012 zero  out  1  result == 0.
REQ-013 overflow  out  1  signed overflow for ADD/SUB, 0 for logic ops.

Function
REQ-014 Block SHALL compute the WIDTH-bit operation bit-serially, LSB first, with one 1-bit ALU slice reused once per cycle.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after WIDTH bit cycles; DONE->IDLE unconditionally after one cycle.
REQ-016 On accepted start: latch a, b, op into shift/hold registers; clear bit counter; carry register = 1 for SUB, else 0; clear result.
REQ-017 Per-bit slice control: AND ainvert0 binvert0 sel00; OR 0/0 sel01; ADD 0/0 sel10; SUB binvert1 sel10; NOR ainvert1 binvert1 sel00.
REQ-018 Each RUN cycle: slice inputs = LSB of A/B shift regs and carry reg; slice out shifted into result MSB; A/B shifted right; carry reg updated with slice cout (ADD/SUB only).
REQ-019 Bit counter SHALL count 0..WIDTH-1; RUN exits when counter = WIDTH-1 processed; no wrap beyond.
REQ-020 Carry into MSB SHALL be recorded; overflow = carry_in_msb XOR carry_out_msb for ADD/SUB.
REQ-021 Latency: done SHALL be high for exactly one cycle, asserted after WIDTH+1 rising edges following the edge that sampled start.
REQ-022 cout, zero, overflow SHALL update together with done and hold until next accepted start.
REQ-023 start while busy (RUN or DONE) SHALL be ignored, no effect on operands or progress.
REQ-024 start asserted continuously SHALL launch a new operation on the first IDLE cycle after DONE (back-to-back period WIDTH+2).
REQ-025 Reserved op codes SHALL run full latency and complete with result 0, cout 0, overflow 0, zero 1.
REQ-026 Operand inputs SHALL be don't-care except on the start-accept edge.

Reset
REQ-027 rst at any edge, including mid-RUN, SHALL force IDLE and abort the operation.
REQ-028 After reset: busy 0, done 0, result 0, cout 0, zero 0, overflow 0, counter 0, carry 0.
REQ-029 rst has priority over start on the same edge.

Structure
REQ-030 Shared package alu_pkg SHALL hold op encoding enum, FSM state enum, default WIDTH constant.
REQ-031 One sub-module: the existing 1-bit ALU slice alu1b (a, b, ainvert, binvert, cin, s1, s0 -> x, cout), instantiated once.
REQ-032 Counter width SHALL be $clog2(WIDTH) bits.

Verification
REQ-033 ADD a=0x0F b=0x01 -> result 0x10, cout 0, overflow 0, zero 0; done on 9th edge after start edge.
REQ-034 SUB a=0x05 b=0x05 -> result 0x00, zero 1, cout 1, overflow 0; SUB 0x00-0x01 -> 0xFF, cout 0, overflow 0.
REQ-035 ADD a=0x7F b=0x01 -> result 0x80, overflow 1, cout 0; ADD 0xFF+0x01 -> 0x00, cout 1, zero 1.
REQ-036 a=0xF0 b=0x3C: AND -> 0x30, OR -> 0xFC, NOR -> 0x03; cout 0, overflow 0 each.
REQ-037 start pulsed at bit 3 of running ADD -> ignored, original result correct; rst at bit 4 -> next cycle busy 0, result 0, no done; fresh ADD 0x02+0x03 -> 0x05.
REQ-038 start held high across three ops -> done pulses every 10 cycles, busy low exactly one cycle between ops.
